// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU op encodings, mnemonic codes and mnemonic decoder
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'd0;
    localparam logic [3:0] ALU_OR   = 4'd1;
    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_SUB  = 4'd6;
    localparam logic [3:0] ALU_SLT  = 4'd7;
    localparam logic [3:0] ALU_NOR  = 4'd12;
    localparam logic [3:0] ALU_NAND = 4'd13;

    localparam logic [2:0] MNEM_AND  = 3'd0;
    localparam logic [2:0] MNEM_OR   = 3'd1;
    localparam logic [2:0] MNEM_ADD  = 3'd2;
    localparam logic [2:0] MNEM_SUB  = 3'd3;
    localparam logic [2:0] MNEM_SLT  = 3'd4;
    localparam logic [2:0] MNEM_NOR  = 3'd5;
    localparam logic [2:0] MNEM_NAND = 3'd6;
    localparam logic [2:0] MNEM_RSVD = 3'd7;

    typedef struct packed {
        logic       illegal;
        logic [3:0] op;
    } decode_t;

    function automatic decode_t mnem_to_op(input logic [2:0] mnem);
        decode_t d;
        d.illegal = 1'b0;
        d.op      = ALU_AND;
        case (mnem)
            MNEM_AND:  d.op = ALU_AND;
            MNEM_OR:   d.op = ALU_OR;
            MNEM_ADD:  d.op = ALU_ADD;
            MNEM_SUB:  d.op = ALU_SUB;
            MNEM_SLT:  d.op = ALU_SLT;
            MNEM_NOR:  d.op = ALU_NOR;
            MNEM_NAND: d.op = ALU_NAND;
            default:   d.illegal = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - circular-pointer FIFO storage; occupancy is tracked by the owner
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    // DEPTH is a power of two, so the pointers wrap by plain overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/alu_issue_queue.sv
// rtl/alu_issue_queue.sv - decodes ALU requests, rejects illegal mnemonics, queues the rest
module alu_issue_queue
    import alu_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               in_mnem,
    input  logic [DATA_W-1:0]        in_a,
    input  logic [DATA_W-1:0]        in_b,
    input  logic [TAG_W-1:0]         in_tag,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [3:0]               out_op,
    output logic [DATA_W-1:0]        out_a,
    output logic [DATA_W-1:0]        out_b,
    output logic [TAG_W-1:0]         out_tag,
    output logic                     illegal,
    output logic [TAG_W-1:0]         illegal_tag,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = 4 + 2 * DATA_W + TAG_W;

    decode_t        dec;
    logic           accept;
    logic           push;
    logic           pop;
    logic [CW-1:0]  count_next;
    logic [EW-1:0]  wdata;
    logic [EW-1:0]  rdata;

    assign dec      = mnem_to_op(in_mnem);
    assign in_ready = (count != CW'(DEPTH));

    // Illegal requests complete the handshake but never occupy a slot
    assign accept = in_valid && in_ready && !flush;
    assign push   = accept && !dec.illegal;
    assign pop    = out_valid && out_ready && !flush;

    always_comb begin
        count_next = count;
        if (flush) begin
            count_next = '0;
        end else begin
            case ({push, pop})
                2'b10:   count_next = count + CW'(1);
                2'b01:   count_next = count - CW'(1);
                default: count_next = count;
            endcase
        end
    end

    // out_valid is registered alongside count so it never depends on a decode of count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count       <= '0;
            out_valid   <= 1'b0;
            illegal     <= 1'b0;
            illegal_tag <= '0;
        end else begin
            count     <= count_next;
            out_valid <= (count_next != '0);
            illegal   <= accept && dec.illegal;
            if (accept && dec.illegal) illegal_tag <= in_tag;
        end
    end

    assign wdata = {dec.op, in_a, in_b, in_tag};

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (wdata),
        .rdata (rdata)
    );

    assign {out_op, out_a, out_b, out_tag} = rdata;

endmodule

// File: tb/tb_alu_issue_queue.sv
// tb/tb_alu_issue_queue.sv - table-driven and randomized self-checking bench for alu_issue_queue
module tb_alu_issue_queue;

    localparam int DATA_W = 64;
    localparam int DEPTH  = 4;
    localparam int TAG_W  = 5;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [2:0]         in_mnem;
    logic [DATA_W-1:0]  in_a;
    logic [DATA_W-1:0]  in_b;
    logic [TAG_W-1:0]   in_tag;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic [3:0]         out_op;
    logic [DATA_W-1:0]  out_a;
    logic [DATA_W-1:0]  out_b;
    logic [TAG_W-1:0]   out_tag;
    logic               illegal;
    logic [TAG_W-1:0]   illegal_tag;
    logic [2:0]         count;

    alu_issue_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_mnem(in_mnem),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
        .out_a(out_a), .out_b(out_b), .out_tag(out_tag),
        .illegal(illegal), .illegal_tag(illegal_tag), .count(count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] ref_op(input logic [2:0] m);
        logic [3:0] tbl [7] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12, 4'd13};
        return tbl[m];
    endfunction

    typedef struct {
        logic        v;
        logic [2:0]  m;
        logic [63:0] a;
        logic [4:0]  tag;
        logic        fl;
        logic        ordy;
        logic        ev;
        logic [3:0]  eop;
        logic [63:0] ea;
        logic [4:0]  etag;
        int          ecnt;
        logic        eill;
        logic [4:0]  eitag;
        logic        erdy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic v, input logic [2:0] m, input logic [63:0] a, input logic [4:0] tag,
                       input logic fl, input logic ordy, input logic ev, input logic [3:0] eop,
                       input logic [63:0] ea, input logic [4:0] etag, input int ecnt,
                       input logic eill, input logic [4:0] eitag, input logic erdy);
        vec_t r;
        r.v = v; r.m = m; r.a = a; r.tag = tag; r.fl = fl; r.ordy = ordy;
        r.ev = ev; r.eop = eop; r.ea = ea; r.etag = etag; r.ecnt = ecnt;
        r.eill = eill; r.eitag = eitag; r.erdy = erdy;
        vecs.push_back(r);
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [4:0]  tag;
    } ent_t;

    ent_t        mq[$];
    logic        m_ill;
    logic [4:0]  m_itag;

    task automatic idle_inputs();
        in_valid = 1'b0; in_mnem = '0; in_a = '0; in_b = '0; in_tag = '0;
        flush = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("reset.out_valid", out_valid, 0);
        chk("reset.count", count, 0);
        chk("reset.illegal", illegal, 0);
        chk("reset.illegal_tag", illegal_tag, 0);
        chk("reset.in_ready", in_ready, 1);

        // b is always driven as a+2, so the first ADD sees a=5, b=7
        //   v  m  a   tag fl rdy | ev op  a   tag cnt ill itag rdy
        add(1, 2,  5,  3, 0, 1,   1, 2,  5,  3, 1, 0, 0,  1);
        add(0, 0,  0,  0, 0, 1,   0, 0,  0,  0, 0, 0, 0,  1);
        add(1, 3, 11, 11, 0, 0,   1, 6, 11, 11, 1, 0, 0,  1);
        add(1, 4, 12, 12, 0, 0,   1, 6, 11, 11, 2, 0, 0,  1);
        add(1, 5, 13, 13, 0, 0,   1, 6, 11, 11, 3, 0, 0,  1);
        add(1, 6, 14, 14, 0, 0,   1, 6, 11, 11, 4, 0, 0,  0);
        add(1, 0, 15, 15, 0, 0,   1, 6, 11, 11, 4, 0, 0,  0);
        add(1, 1, 16, 16, 0, 0,   1, 6, 11, 11, 4, 0, 0,  0);
        add(1, 0, 15, 15, 0, 1,   1, 7, 12, 12, 3, 0, 0,  1);
        add(1, 0, 15, 15, 0, 1,   1, 12, 13, 13, 3, 0, 0, 1);
        add(1, 1, 16, 16, 0, 1,   1, 13, 14, 14, 3, 0, 0, 1);
        add(0, 0,  0,  0, 0, 1,   1, 0, 15, 15, 2, 0, 0,  1);
        add(0, 0,  0,  0, 0, 1,   1, 1, 16, 16, 1, 0, 0,  1);
        add(0, 0,  0,  0, 0, 1,   0, 0,  0,  0, 0, 0, 0,  1);
        add(1, 7,  0, 17, 0, 0,   0, 0,  0,  0, 0, 1, 17, 1);
        add(0, 0,  0,  0, 0, 0,   0, 0,  0,  0, 0, 0, 17, 1);
        add(1, 7,  0, 20, 0, 0,   0, 0,  0,  0, 0, 1, 20, 1);
        add(1, 7,  0, 21, 0, 0,   0, 0,  0,  0, 0, 1, 21, 1);
        add(0, 0,  0,  0, 0, 0,   0, 0,  0,  0, 0, 0, 21, 1);
        add(1, 2, 30, 22, 0, 0,   1, 2, 30, 22, 1, 0, 21, 1);
        add(1, 2, 31, 23, 0, 0,   1, 2, 30, 22, 2, 0, 21, 1);
        add(1, 2, 32, 24, 0, 0,   1, 2, 30, 22, 3, 0, 21, 1);
        add(1, 2, 33, 25, 1, 1,   0, 0,  0,  0, 0, 0, 21, 1);
        add(1, 7,  0,  9, 1, 0,   0, 0,  0,  0, 0, 0, 21, 1);
        add(1, 3, 40, 26, 0, 0,   1, 6, 40, 26, 1, 0, 21, 1);
        add(1, 0, 41, 27, 0, 0,   1, 6, 40, 26, 2, 0, 21, 1);
        add(1, 7,  0, 18, 0, 0,   1, 6, 40, 26, 2, 1, 18, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            in_valid  = vecs[i].v;
            in_mnem   = vecs[i].m;
            in_a      = vecs[i].a;
            in_b      = vecs[i].a + 64'd2;
            in_tag    = vecs[i].tag;
            flush     = vecs[i].fl;
            out_ready = vecs[i].ordy;
            tick();
            chk($sformatf("vec%0d.out_valid", i), out_valid, vecs[i].ev);
            if (vecs[i].ev) begin
                chk($sformatf("vec%0d.out_op", i), out_op, vecs[i].eop);
                chk($sformatf("vec%0d.out_a", i), out_a, vecs[i].ea);
                chk($sformatf("vec%0d.out_b", i), out_b, vecs[i].ea + 64'd2);
                chk($sformatf("vec%0d.out_tag", i), out_tag, vecs[i].etag);
            end
            chk($sformatf("vec%0d.count", i), count, vecs[i].ecnt);
            chk($sformatf("vec%0d.illegal", i), illegal, vecs[i].eill);
            chk($sformatf("vec%0d.illegal_tag", i), illegal_tag, vecs[i].eitag);
            chk($sformatf("vec%0d.in_ready", i), in_ready, vecs[i].erdy);
        end

        // Asynchronous reset mid-cycle with two entries queued
        idle_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async.out_valid", out_valid, 0);
        chk("async.count", count, 0);
        chk("async.illegal_tag", illegal_tag, 0);
        #1;
        rst_n = 1'b1;
        #1;
        chk("async.in_ready", in_ready, 1);
        in_valid = 1'b1; in_mnem = 3'd5; in_a = 64'd50; in_b = 64'd51; in_tag = 5'd28;
        tick();
        in_valid = 1'b0;
        chk("async.first.out_valid", out_valid, 1);
        chk("async.first.out_op", out_op, 12);
        chk("async.first.out_a", out_a, 50);
        chk("async.first.out_tag", out_tag, 28);
        chk("async.first.count", count, 1);

        // Randomized phase against a queue-based reference model
        idle_inputs();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        mq.delete();
        m_ill  = 1'b0;
        m_itag = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            logic acc;
            logic is_ill;
            logic do_pop;
            ent_t e;
            in_valid  = ($urandom_range(0, 9) < 7);
            in_mnem   = 3'($urandom_range(0, 7));
            in_a      = {$urandom, $urandom};
            in_b      = {$urandom, $urandom};
            in_tag    = 5'($urandom);
            flush     = ($urandom_range(0, 24) == 0);
            out_ready = ($urandom_range(0, 1) == 1);
            #1;
            chk($sformatf("rnd%0d.in_ready", cyc), in_ready, mq.size() < DEPTH);
            acc    = in_valid && (mq.size() < DEPTH) && !flush;
            is_ill = acc && (in_mnem == 3'd7);
            do_pop = (mq.size() > 0) && out_ready && !flush;
            if (flush) begin
                mq.delete();
            end else begin
                if (do_pop) void'(mq.pop_front());
                if (acc && !is_ill) begin
                    e.op = ref_op(in_mnem); e.a = in_a; e.b = in_b; e.tag = in_tag;
                    mq.push_back(e);
                end
            end
            m_ill = is_ill;
            if (is_ill) m_itag = in_tag;
            tick();
            chk($sformatf("rnd%0d.out_valid", cyc), out_valid, mq.size() > 0);
            chk($sformatf("rnd%0d.count", cyc), count, mq.size());
            chk($sformatf("rnd%0d.illegal", cyc), illegal, m_ill);
            chk($sformatf("rnd%0d.illegal_tag", cyc), illegal_tag, m_itag);
            if (mq.size() > 0) begin
                chk($sformatf("rnd%0d.out_op", cyc), out_op, mq[0].op);
                chk($sformatf("rnd%0d.out_a", cyc), out_a, mq[0].a);
                chk($sformatf("rnd%0d.out_b", cyc), out_b, mq[0].b);
                chk($sformatf("rnd%0d.out_tag", cyc), out_tag, mq[0].tag);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
